// File: rtl/rv_pkg.sv
// Shared RV32IM decode definitions: opcode/funct7 constants and the decoded
// bundle that travels from the decode stage into the execute-stage ALU.
package rv_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;

  typedef struct packed {
    logic add;
    logic sub;
    logic mul;
    logic mulh;
    logic mulhsu;
    logic mulhu;
    logic op_and;
    logic op_or;
    logic op_xor;
    logic sll;
    logic srl;
    logic sra;
    logic slt;
    logic sltu;
  } alu_sel_t;

  // imm is always 32 bits here; the stage extends it to its datapath width
  typedef struct packed {
    alu_sel_t    sel;
    logic [31:0] imm;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic        use_imm;
    logic        reg_write;
    logic        illegal;
  } decode_bundle_t;

endpackage

// File: rtl/alu_decode_comb.sv
// Pure combinational decode of one RV32IM instruction (OP, OP-IMM, LUI)
// into the ALU select/operand bundle.
module alu_decode_comb
  import rv_pkg::*;
(
  input  logic [31:0]    instr,
  output decode_bundle_t bundle
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       illegal_d;
  alu_sel_t   sel_d;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  always_comb begin
    sel_d           = '0;
    illegal_d       = 1'b0;
    bundle          = '0;
    bundle.rs1_addr = instr[19:15];
    bundle.rs2_addr = instr[24:20];
    bundle.rd_addr  = instr[11:7];

    unique case (opcode)
      OPC_OP: begin
        unique case (funct7)
          F7_BASE: begin
            unique case (funct3)
              3'b000: sel_d.add    = 1'b1;
              3'b001: sel_d.sll    = 1'b1;
              3'b010: sel_d.slt    = 1'b1;
              3'b011: sel_d.sltu   = 1'b1;
              3'b100: sel_d.op_xor = 1'b1;
              3'b101: sel_d.srl    = 1'b1;
              3'b110: sel_d.op_or  = 1'b1;
              default: sel_d.op_and = 1'b1;
            endcase
          end
          F7_ALT: begin
            if (funct3 == 3'b000)      sel_d.sub = 1'b1;
            else if (funct3 == 3'b101) sel_d.sra = 1'b1;
            else                       illegal_d = 1'b1;
          end
          F7_MULDIV: begin
            // No divider in this core: div/divu/rem/remu trap as illegal
            unique case (funct3)
              3'b000:  sel_d.mul    = 1'b1;
              3'b001:  sel_d.mulh   = 1'b1;
              3'b010:  sel_d.mulhsu = 1'b1;
              3'b011:  sel_d.mulhu  = 1'b1;
              default: illegal_d    = 1'b1;
            endcase
          end
          default: illegal_d = 1'b1;
        endcase
      end

      OPC_OP_IMM: begin
        bundle.use_imm  = 1'b1;
        bundle.rs2_addr = 5'd0;
        bundle.imm      = {{20{instr[31]}}, instr[31:20]};
        unique case (funct3)
          3'b000: sel_d.add    = 1'b1;
          3'b010: sel_d.slt    = 1'b1;
          3'b011: sel_d.sltu   = 1'b1;
          3'b100: sel_d.op_xor = 1'b1;
          3'b110: sel_d.op_or  = 1'b1;
          3'b111: sel_d.op_and = 1'b1;
          3'b001: begin
            bundle.imm = {27'd0, instr[24:20]};
            if (funct7 == F7_BASE) sel_d.sll = 1'b1;
            else                   illegal_d = 1'b1;
          end
          default: begin
            bundle.imm = {27'd0, instr[24:20]};
            if (funct7 == F7_BASE)     sel_d.srl = 1'b1;
            else if (funct7 == F7_ALT) sel_d.sra = 1'b1;
            else                       illegal_d = 1'b1;
          end
        endcase
      end

      OPC_LUI: begin
        sel_d.add       = 1'b1;
        bundle.use_imm  = 1'b1;
        bundle.rs1_addr = 5'd0;
        bundle.rs2_addr = 5'd0;
        bundle.imm      = {instr[31:12], 12'd0};
      end

      default: illegal_d = 1'b1;
    endcase

    // An illegal bundle carries no select so the one-hot invariant holds
    bundle.sel       = illegal_d ? '0 : sel_d;
    bundle.illegal   = illegal_d;
    bundle.reg_write = !illegal_d && (instr[11:7] != 5'd0);
  end

endmodule

// File: rtl/alu_decode_stage.sv
// Registered decode stage: single-entry pipeline register with valid/ready
// handshake and flush around the combinational RV32IM decoder.
module alu_decode_stage
  import rv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [WIDTH-1:0] pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_pc,
  output logic [4:0]       rs1_addr,
  output logic [4:0]       rs2_addr,
  output logic [4:0]       rd_addr,
  output logic             use_imm,
  output logic [WIDTH-1:0] imm,
  output logic             reg_write,
  output logic             illegal,
  output logic             alu_sel_add,
  output logic             alu_sel_sub,
  output logic             alu_sel_mul,
  output logic             alu_sel_mulh,
  output logic             alu_sel_mulhsu,
  output logic             alu_sel_mulhu,
  output logic             alu_sel_and,
  output logic             alu_sel_or,
  output logic             alu_sel_xor,
  output logic             alu_sel_sll,
  output logic             alu_sel_srl,
  output logic             alu_sel_sra,
  output logic             alu_sel_slt,
  output logic             alu_sel_sltu
);

  decode_bundle_t  bundle_d, bundle_q;
  logic [WIDTH-1:0] pc_d, pc_q;
  logic            valid_d, valid_q;
  logic            load;

  alu_decode_comb u_decode (
    .instr  (instr),
    .bundle (bundle_d)
  );

  assign in_ready = !valid_q || out_ready;
  assign load     = in_valid && in_ready && !flush;

  // Flush beats load; data regs only move on a load so stalls are bit-exact
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      pc_d    = pc;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      pc_q     <= '0;
      bundle_q <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      if (load) bundle_q <= bundle_d;
    end
  end

  generate
    if (WIDTH > 32) begin : g_imm_sext
      assign imm = {{(WIDTH-32){bundle_q.imm[31]}}, bundle_q.imm};
    end else begin : g_imm_trunc
      assign imm = bundle_q.imm[WIDTH-1:0];
    end
  endgenerate

  assign out_valid      = valid_q;
  assign out_pc         = pc_q;
  assign rs1_addr       = bundle_q.rs1_addr;
  assign rs2_addr       = bundle_q.rs2_addr;
  assign rd_addr        = bundle_q.rd_addr;
  assign use_imm        = bundle_q.use_imm;
  assign reg_write      = bundle_q.reg_write;
  assign illegal        = bundle_q.illegal;
  assign alu_sel_add    = bundle_q.sel.add;
  assign alu_sel_sub    = bundle_q.sel.sub;
  assign alu_sel_mul    = bundle_q.sel.mul;
  assign alu_sel_mulh   = bundle_q.sel.mulh;
  assign alu_sel_mulhsu = bundle_q.sel.mulhsu;
  assign alu_sel_mulhu  = bundle_q.sel.mulhu;
  assign alu_sel_and    = bundle_q.sel.op_and;
  assign alu_sel_or     = bundle_q.sel.op_or;
  assign alu_sel_xor    = bundle_q.sel.op_xor;
  assign alu_sel_sll    = bundle_q.sel.sll;
  assign alu_sel_srl    = bundle_q.sel.srl;
  assign alu_sel_sra    = bundle_q.sel.sra;
  assign alu_sel_slt    = bundle_q.sel.slt;
  assign alu_sel_sltu   = bundle_q.sel.sltu;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed-vector bench for alu_decode_stage with hand-computed expectations.
module tb_alu_decode_stage;

  localparam int WIDTH = 32;

  // Select bus packed as {add,sub,mul,mulh,mulhsu,mulhu,and,or,xor,sll,srl,sra,slt,sltu}
  localparam logic [13:0] S_ADD    = 14'b10000000000000;
  localparam logic [13:0] S_SUB    = 14'b01000000000000;
  localparam logic [13:0] S_MUL    = 14'b00100000000000;
  localparam logic [13:0] S_MULHSU = 14'b00001000000000;
  localparam logic [13:0] S_AND    = 14'b00000010000000;
  localparam logic [13:0] S_SRA    = 14'b00000000000100;
  localparam logic [13:0] S_SLTU   = 14'b00000000000001;
  localparam logic [13:0] S_NONE   = 14'b00000000000000;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instr;
  logic [WIDTH-1:0] pc;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_pc;
  logic [4:0]       rs1_addr, rs2_addr, rd_addr;
  logic             use_imm;
  logic [WIDTH-1:0] imm;
  logic             reg_write;
  logic             illegal;
  logic s_add, s_sub, s_mul, s_mulh, s_mulhsu, s_mulhu, s_and, s_or, s_xor;
  logic s_sll, s_srl, s_sra, s_slt, s_sltu;
  logic [13:0]      sels;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign sels = {s_add, s_sub, s_mul, s_mulh, s_mulhsu, s_mulhu, s_and, s_or,
                 s_xor, s_sll, s_srl, s_sra, s_slt, s_sltu};

  alu_decode_stage #(.WIDTH(WIDTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .instr          (instr),
    .pc             (pc),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .rs1_addr       (rs1_addr),
    .rs2_addr       (rs2_addr),
    .rd_addr        (rd_addr),
    .use_imm        (use_imm),
    .imm            (imm),
    .reg_write      (reg_write),
    .illegal        (illegal),
    .alu_sel_add    (s_add),
    .alu_sel_sub    (s_sub),
    .alu_sel_mul    (s_mul),
    .alu_sel_mulh   (s_mulh),
    .alu_sel_mulhsu (s_mulhsu),
    .alu_sel_mulhu  (s_mulhu),
    .alu_sel_and    (s_and),
    .alu_sel_or     (s_or),
    .alu_sel_xor    (s_xor),
    .alu_sel_sll    (s_sll),
    .alu_sel_srl    (s_srl),
    .alu_sel_sra    (s_sra),
    .alu_sel_slt    (s_slt),
    .alu_sel_sltu   (s_sltu)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_bundle(input string tag, input logic [13:0] e_sel,
                               input logic [31:0] e_imm, input logic [4:0] e_rs1,
                               input logic [4:0] e_rs2, input logic [4:0] e_rd,
                               input logic e_use_imm, input logic e_reg_write,
                               input logic e_illegal, input logic [31:0] e_pc);
    check({tag, ".valid"},   64'(out_valid), 64'd1);
    check({tag, ".sel"},     64'(sels),      64'(e_sel));
    check({tag, ".imm"},     64'(imm),       64'(e_imm));
    check({tag, ".rs1"},     64'(rs1_addr),  64'(e_rs1));
    check({tag, ".rs2"},     64'(rs2_addr),  64'(e_rs2));
    check({tag, ".rd"},      64'(rd_addr),   64'(e_rd));
    check({tag, ".use_imm"}, 64'(use_imm),   64'(e_use_imm));
    check({tag, ".rwr"},     64'(reg_write), 64'(e_reg_write));
    check({tag, ".illegal"}, 64'(illegal),   64'(e_illegal));
    check({tag, ".pc"},      64'(out_pc),    64'(e_pc));
    check({tag, ".onehot"},  64'($countones(sels) + int'(illegal)), 64'd1);
    $display("txn %s: sel=%b imm=0x%08h rd=%0d pc=0x%0h", tag, sels, imm, rd_addr, out_pc);
  endtask

  task automatic expect_zero(input string tag);
    check({tag, ".valid"},   64'(out_valid), 64'd0);
    check({tag, ".sel"},     64'(sels),      64'd0);
    check({tag, ".imm"},     64'(imm),       64'd0);
    check({tag, ".pc"},      64'(out_pc),    64'd0);
    check({tag, ".addrs"},   64'({rs1_addr, rs2_addr, rd_addr}), 64'd0);
    check({tag, ".flags"},   64'({use_imm, reg_write, illegal}), 64'd0);
    $display("txn %s: reset state out_valid=%0d", tag, out_valid);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; instr = '0; pc = '0; flush = 1'b0; out_ready = 1'b1;
    tick(); tick();
    expect_zero("reset");
    check("reset.in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;

    // Back-to-back stream at one instruction per cycle
    in_valid = 1'b1; instr = 32'h002081B3; pc = 32'h100; tick();
    expect_bundle("add", S_ADD, 32'h0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, 32'h100);
    instr = 32'h027322B3; pc = 32'h104; tick();
    expect_bundle("mulhsu", S_MULHSU, 32'h0, 5'd6, 5'd7, 5'd5, 1'b0, 1'b1, 1'b0, 32'h104);
    instr = 32'h402081B3; pc = 32'h108; tick();
    expect_bundle("sub", S_SUB, 32'h0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, 32'h108);
    instr = 32'hFFF00093; pc = 32'h10C; tick();
    expect_bundle("addi", S_ADD, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd1, 1'b1, 1'b1, 1'b0, 32'h10C);
    instr = 32'h4030D113; pc = 32'h110; tick();
    expect_bundle("srai", S_SRA, 32'h3, 5'd1, 5'd0, 5'd2, 1'b1, 1'b1, 1'b0, 32'h110);
    instr = 32'h0FF0F093; pc = 32'h114; tick();
    expect_bundle("andi", S_AND, 32'hFF, 5'd1, 5'd0, 5'd1, 1'b1, 1'b1, 1'b0, 32'h114);
    instr = 32'h0020B1B3; pc = 32'h118; tick();
    expect_bundle("sltu", S_SLTU, 32'h0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, 32'h118);
    instr = 32'h123450B7; pc = 32'h11C; tick();
    expect_bundle("lui", S_ADD, 32'h12345000, 5'd0, 5'd0, 5'd1, 1'b1, 1'b1, 1'b0, 32'h11C);
    instr = 32'h00208033; pc = 32'h120; tick();
    expect_bundle("add_x0", S_ADD, 32'h0, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 32'h120);
    instr = 32'h0220C1B3; pc = 32'h124; tick();
    expect_bundle("div", S_NONE, 32'h0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 32'h124);
    instr = 32'h0000007F; pc = 32'h128; tick();
    expect_bundle("badop", S_NONE, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 32'h128);
    instr = 32'h02009093; pc = 32'h12C; tick();
    expect_bundle("slli_f7", S_NONE, 32'h0, 5'd1, 5'd0, 5'd1, 1'b1, 1'b0, 1'b1, 32'h12C);

    // Drain with nothing offered
    in_valid = 1'b0; tick();
    check("drain.valid", 64'(out_valid), 64'd0);

    // Stall: load add, then hold out_ready low for 3 cycles while a sub is offered
    in_valid = 1'b1; instr = 32'h002081B3; pc = 32'h200; tick();
    out_ready = 1'b0; instr = 32'h402081B3; pc = 32'h204;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall.in_ready", 64'(in_ready), 64'd0);
      expect_bundle("stall", S_ADD, 32'h0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, 32'h200);
    end
    out_ready = 1'b1; #1;
    check("release.in_ready", 64'(in_ready), 64'd1);
    tick();
    expect_bundle("release", S_SUB, 32'h0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, 32'h204);

    // Flush with out_valid=1 and a new instruction offered: both discarded
    flush = 1'b1; instr = 32'h027322B3; pc = 32'h208; tick();
    check("flush.valid", 64'(out_valid), 64'd0);
    flush = 1'b0; in_valid = 1'b0; tick();
    check("flush.dropped", 64'(out_valid), 64'd0);

    // Reset asserted in the middle of a stall
    in_valid = 1'b1; instr = 32'h027302B3; pc = 32'h300; tick();
    out_ready = 1'b0; in_valid = 1'b0; tick();
    check("pre_rst.valid", 64'(out_valid), 64'd1);
    check("pre_rst.sel", 64'(sels), 64'(S_MUL));
    rst_n = 1'b0; tick();
    expect_zero("mid_rst");
    rst_n = 1'b1; out_ready = 1'b1; tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
